// File: rtl/blake2_block_assembler.sv
// Packs a byte stream into little-endian BLAKE2b message blocks.
// Each block carries its running byte count and a final-block flag.
module blake2_block_assembler #(
  parameter int BLOCK_BYTES = 128,
  parameter int CNT_W       = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  input  logic                     flush,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic [8*BLOCK_BYTES-1:0] blk_data,
  output logic [CNT_W-1:0]         blk_count,
  output logic                     blk_last
);

  localparam int PTR_W = $clog2(BLOCK_BYTES);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] tot;

  assign in_ready  = (state == FILL) && !reset;
  assign blk_valid = (state == HOLD);

  // The buffer is zeroed after every handshake, so bytes past ptr are the padding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      ptr       <= '0;
      tot       <= '0;
      blk_data  <= '0;
      blk_count <= '0;
      blk_last  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            blk_data[{ptr, 3'b000} +: 8] <= in_data;
            ptr <= ptr + PTR_W'(1);
            tot <= tot + CNT_W'(1);
            if ((ptr == PTR_W'(BLOCK_BYTES - 1)) || in_last || flush) begin
              state     <= HOLD;
              blk_count <= tot + CNT_W'(1);
              blk_last  <= in_last | flush;
            end
          end else if (flush) begin
            state     <= HOLD;
            blk_count <= tot;
            blk_last  <= 1'b1;
          end
        end
        HOLD: begin
          if (blk_ready) begin
            state    <= FILL;
            ptr      <= '0;
            blk_data <= '0;
            if (blk_last) begin
              tot <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2_block_assembler.sv
// Randomized bench for blake2_block_assembler against a message-level block model.
module tb_blake2_block_assembler;

  localparam int BB    = 128;
  localparam int CNT_W = 64;

  typedef logic [1023:0] wide_t;
  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [8*BB-1:0] data;
    logic [CNT_W-1:0] count;
    logic last;
  } blk_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_data = '0;
  logic in_last = 1'b0;
  logic flush = 1'b0;
  logic blk_valid;
  logic blk_ready = 1'b0;
  logic [8*BB-1:0] blk_data;
  logic [CNT_W-1:0] blk_count;
  logic blk_last;

  blake2_block_assembler #(.BLOCK_BYTES(BB), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .flush(flush),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_count(blk_count), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  blk_t exp_q[$];
  int rdy_mode = 2;
  bit hold_prev = 0;
  bit expect_valid = 0;
  int fill_cnt = 0;
  logic [8*BB-1:0] saved_data;
  logic [CNT_W-1:0] saved_count;
  logic saved_last;

  task automatic checkOutput(input string tag, input wide_t got, input wide_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Message-level model: split into BB-byte chunks; a flush after a full chunk adds an empty final block.
  task automatic buildExpected(input byte_q_t msg, input int mode);
    int len = msg.size();
    blk_t b;
    for (int s = 0; s < len; s += BB) begin
      int n = (len - s < BB) ? (len - s) : BB;
      b.data = '0;
      for (int k = 0; k < n; k++) b.data[8*k +: 8] = msg[s+k];
      b.count = CNT_W'(s + n);
      b.last = ((s + n) == len) && (mode != 2 || n < BB);
      exp_q.push_back(b);
    end
    if (mode == 2 && (len % BB) == 0) begin
      b.data = '0;
      b.count = CNT_W'(len);
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic stepCycle(input bit want, input logic [7:0] val, input bit lst,
                           input bit fl, output bit acc);
    blk_t e;
    @(negedge clk);
    if (expect_valid) checkOutput("latency_valid", wide_t'(blk_valid), wide_t'(1'b1));
    expect_valid = 0;
    if (hold_prev) begin
      checkOutput("hold_valid", wide_t'(blk_valid), wide_t'(1'b1));
      checkOutput("hold_data", wide_t'(blk_data), wide_t'(saved_data));
      checkOutput("hold_count", wide_t'(blk_count), wide_t'(saved_count));
      checkOutput("hold_last", wide_t'(blk_last), wide_t'(saved_last));
    end
    checkOutput("in_ready", wide_t'(in_ready), wide_t'(!blk_valid));
    blk_ready = (rdy_mode == 2) ? 1'($urandom % 2) : 1'(rdy_mode);
    if (blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_blk", wide_t'(1'b1), wide_t'(1'b0));
      end else begin
        e = exp_q.pop_front();
        checkOutput("blk_data", wide_t'(blk_data), wide_t'(e.data));
        checkOutput("blk_count", wide_t'(blk_count), wide_t'(e.count));
        checkOutput("blk_last", wide_t'(blk_last), wide_t'(e.last));
      end
    end
    hold_prev = blk_valid && !blk_ready;
    saved_data = blk_data;
    saved_count = blk_count;
    saved_last = blk_last;
    in_valid = want;
    in_data = want ? val : 8'($urandom);
    in_last = lst;
    flush = fl;
    acc = in_ready && (want || fl);
    if (in_ready && want) begin
      fill_cnt++;
      if (fill_cnt == BB || lst || fl) begin
        expect_valid = 1;
        fill_cnt = 0;
      end
    end else if (in_ready && fl) begin
      expect_valid = 1;
      fill_cnt = 0;
    end
  endtask

  // mode 0: in_last on final byte, 1: flush on final byte, 2: separate flush afterwards
  task automatic applyStimulus(input byte_q_t msg, input int mode);
    bit acc;
    bit want;
    bit is_end;
    int guard;
    buildExpected(msg, mode);
    for (int i = 0; i < msg.size(); i++) begin
      guard = 0;
      do begin
        want = ($urandom % 4) != 0;
        is_end = want && (i == msg.size() - 1);
        stepCycle(want, msg[i], is_end && mode == 0, is_end && mode == 1, acc);
        guard++;
      end while (!(acc && want) && guard < 2000);
      if (guard >= 2000) begin
        checkOutput("timeout_byte", wide_t'(1'b1), wide_t'(1'b0));
        return;
      end
    end
    if (mode == 2) begin
      guard = 0;
      do begin
        stepCycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        guard++;
      end while (!acc && guard < 2000);
      if (guard >= 2000) checkOutput("timeout_flush", wide_t'(1'b1), wide_t'(1'b0));
    end
  endtask

  task automatic drain();
    bit acc;
    int guard = 0;
    while ((exp_q.size() != 0 || blk_valid) && guard < 2000) begin
      stepCycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
      guard++;
    end
    checkOutput("drain_empty", wide_t'(exp_q.size()), wide_t'(0));
  endtask

  initial begin
    byte_q_t m;
    bit acc;
    int len;
    int mode;

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", wide_t'(in_ready), wide_t'(1'b0));
    checkOutput("rst_valid", wide_t'(blk_valid), wide_t'(1'b0));
    checkOutput("rst_data", wide_t'(blk_data), wide_t'(0));
    checkOutput("rst_count", wide_t'(blk_count), wide_t'(0));
    checkOutput("rst_last", wide_t'(blk_last), wide_t'(1'b0));
    reset = 1'b0;

    m = '{8'h61, 8'h62, 8'h63};
    applyStimulus(m, 0);
    drain();

    m = {};
    for (int i = 0; i < 128; i++) m.push_back(8'(i));
    applyStimulus(m, 0);
    drain();

    m = {};
    for (int i = 0; i < 129; i++) m.push_back(8'(i));
    applyStimulus(m, 0);
    m = '{8'h11, 8'h22};
    applyStimulus(m, 0);
    drain();

    m = {};
    applyStimulus(m, 2);
    m = '{8'hFF};
    applyStimulus(m, 0);
    drain();

    // Consumer stalls for ten cycles on a 5-byte message.
    rdy_mode = 0;
    m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    applyStimulus(m, 1);
    repeat (10) stepCycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
    rdy_mode = 2;
    drain();

    // Reset in the middle of a block discards the partial data.
    for (int i = 0; i < 60; i++) stepCycle(1'b1, 8'($urandom), 1'b0, 1'b0, acc);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    blk_ready = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", wide_t'(blk_valid), wide_t'(1'b0));
    checkOutput("midrst_in_ready", wide_t'(in_ready), wide_t'(1'b0));
    checkOutput("midrst_data", wide_t'(blk_data), wide_t'(0));
    reset = 1'b0;
    fill_cnt = 0;
    hold_prev = 0;
    expect_valid = 0;
    m = '{8'hA5, 8'h5A};
    applyStimulus(m, 0);
    drain();

    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(0, 300);
      if (t % 5 == 0) len = BB * $urandom_range(0, 2);
      mode = (len == 0) ? 2 : $urandom_range(0, 2);
      m = {};
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      applyStimulus(m, mode);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
